octled_bus_arbiter: RTL
=======================

Name: octled_bus_arbiter

Overview:
Shares the 7-segment display peripheral's single register port between two bus requesters: requester 0 is the CPU bridge, requester 1 is the debug/status writer. The block serialises accesses with round-robin arbitration and drives the peripheral's write-enable, address and write-data inputs. It also captures the peripheral's read data and returns ack/err handshakes to the winning requester. It sits between the bridge and the display peripheral.

Parameters:
ADDR_LO, 32'h0000_7f38, lowest byte address accepted by the peripheral window
ADDR_HI, 32'h0000_7f3f, highest byte address accepted (inclusive)

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  asynchronous, active-low reset
r0_req  in  1  requester 0 access request (level)
r0_we  in  1  requester 0: 1=write, 0=read
r0_addr  in  32  requester 0 byte address
r0_wd  in  32  requester 0 write data
r0_ack  out  1  requester 0 completion pulse
r0_err  out  1  requester 0 out-of-window flag, valid with r0_ack
r1_req, r1_we, r1_addr, r1_wd, r1_ack, r1_err  same as requester 0, for requester 1
rdata  out  32  captured read data, valid in the ack cycle
owner  out  1  index of the requester currently being served
t_we  out  1  peripheral write enable
t_addr  out  32  peripheral address
t_wd  out  32  peripheral write data
t_rd  in  32  peripheral combinational read data

Behaviour:
- Reset: clr_n low clears everything immediately. State=IDLE, rr_ptr=0, owner=0. t_we, t_addr, t_wd, rdata = 0. All ack and err outputs = 0.
- Reset taken mid-transaction aborts it. No ack is issued and no t_we pulse is produced.
- All outputs are registered.
- FSM has three states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE: if no request is present, stay in IDLE. If exactly one rN_req is high, grant that requester. If both are high, grant the requester indicated by rr_ptr.
- On grant: latch owner, we, addr and wd, and set in_range = (ADDR_LO <= addr <= ADDR_HI, unsigned). Go to ACCESS.
- ACCESS (1 cycle): t_addr = latched addr if in_range, else 0. t_we = latched we AND in_range. t_wd = latched wd.
- ACCESS, read: at the end of the cycle, rdata <= t_rd if in_range, else 0. Go to DONE.
- DONE (1 cycle): t_we = 0. r<owner>_ack = 1 and r<owner>_err = !in_range. The non-owner's ack and err stay 0. rr_ptr <= ~owner. Go to IDLE.
- For a write, rdata holds its previous value.
- Latency: request first seen in IDLE at cycle N -> t_we high at N+1 -> ack at N+2. Maximum throughput is one access per 3 cycles.
- Handshake: the requester holds req, we, addr and wd stable until it sees ack. It must drop req, or present a new request, in the cycle after ack.
- Requests arriving during ACCESS or DONE are not sampled. They are only considered on return to IDLE.
- Fairness: with both requesters continuously requesting, grants strictly alternate. Neither requester waits more than one other transaction.
- Out-of-window write: no t_we pulse; the access completes with ack=1, err=1.
- t_we is never high for more than one consecutive cycle.

Decomposition:
- Shared package: FSM state encodings (IDLE/ACCESS/DONE, 2-bit), the display window constants 32'h7f38/32'h7f3f, and the 32-bit bus word width.
- One sub-module: rr_arb2. It is a combinational two-way round-robin picker with inputs req[1:0] and rr_ptr, and outputs gnt_valid and gnt_idx.
- rr_ptr, the FSM and the latches live in the top module.

Test Plan:
- Single write: r0 writes addr=32'h7f38, wd=32'h12345678 -> t_we=1 for exactly 1 cycle with t_addr=7f38 and t_wd=12345678 -> r0_ack 1 cycle later with r0_err=0.
- Read: r1 reads addr=32'h7f3c while the bench drives t_rd=32'h0000000a -> t_we stays 0 -> r1_ack with rdata=32'h0000000a and r1_err=0.
- Contention: r0 and r1 both request writes continuously from reset -> grant order r0, r1, r0, r1, with one ack every 3 cycles.
- Out of window: r0 writes addr=32'h7f40 -> t_we stays 0 and t_addr=0 -> r0_ack=1, r0_err=1. A read at 32'h7f37 -> rdata=0, err=1.
- Reset mid-op: assert clr_n=0 during ACCESS of a write -> all outputs 0 immediately. No ack follows after reset is released; a new request then completes normally in 3 cycles.
- Late request: r1_req rises during r0's ACCESS -> r1 is not served until r0's DONE completes, then it is granted in the following IDLE.

Source files
------------

// File: rtl/octled_pkg.sv
// Shared definitions for the 7-segment display bus arbiter: FSM encoding,
// display register window and bus word width.
package octled_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] WIN_LO = 32'h0000_7f38;
    localparam logic [WORD_W-1:0] WIN_HI = 32'h0000_7f3f;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic in_window(input logic [WORD_W-1:0] addr,
                                       input logic [WORD_W-1:0] lo,
                                       input logic [WORD_W-1:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/octled_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// simultaneous requests are settled by rr_ptr.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Pick the winning requester index.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        case (req)
            2'b01: begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b0;
            end
            2'b10: begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b1;
            end
            2'b11: begin
                gnt_valid = 1'b1;
                gnt_idx   = rr_ptr;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_idx   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/octled_bus_arbiter.sv
// Serialises two requesters onto the display peripheral register port
// with round-robin arbitration; one access every three cycles.
module octled_bus_arbiter
    import octled_pkg::*;
#(
    parameter logic [WORD_W-1:0] ADDR_LO = WIN_LO,
    parameter logic [WORD_W-1:0] ADDR_HI = WIN_HI
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [WORD_W-1:0] r0_addr,
    input  logic [WORD_W-1:0] r0_wd,
    output logic              r0_ack,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [WORD_W-1:0] r1_addr,
    input  logic [WORD_W-1:0] r1_wd,
    output logic              r1_ack,
    output logic              r1_err,
    output logic [WORD_W-1:0] rdata,
    output logic              owner,
    output logic              t_we,
    output logic [WORD_W-1:0] t_addr,
    output logic [WORD_W-1:0] t_wd,
    input  logic [WORD_W-1:0] t_rd
);

    state_t            r_state;
    logic              r_rr_ptr;
    logic              r_we;
    logic              r_in_range;

    logic              w_gnt_valid;
    logic              w_gnt_idx;
    logic              w_sel_we;
    logic [WORD_W-1:0] w_sel_addr;
    logic [WORD_W-1:0] w_sel_wd;
    logic              w_sel_in_range;

    rr_arb2 u_arb (
        .req       ({r1_req, r0_req}),
        .rr_ptr    (r_rr_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_sel_we       = w_gnt_idx ? r1_we   : r0_we;
    assign w_sel_addr     = w_gnt_idx ? r1_addr : r0_addr;
    assign w_sel_wd       = w_gnt_idx ? r1_wd   : r0_wd;
    assign w_sel_in_range = in_window(w_sel_addr, ADDR_LO, ADDR_HI);

    // Access FSM; peripheral strobes are registered at grant so they appear in ACCESS.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= 1'b0;
            r_we       <= 1'b0;
            r_in_range <= 1'b0;
            owner      <= 1'b0;
            t_we       <= 1'b0;
            t_addr     <= {WORD_W{1'b0}};
            t_wd       <= {WORD_W{1'b0}};
            rdata      <= {WORD_W{1'b0}};
            r0_ack     <= 1'b0;
            r0_err     <= 1'b0;
            r1_ack     <= 1'b0;
            r1_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r0_ack <= 1'b0;
                    r0_err <= 1'b0;
                    r1_ack <= 1'b0;
                    r1_err <= 1'b0;
                    if (w_gnt_valid) begin
                        owner      <= w_gnt_idx;
                        r_we       <= w_sel_we;
                        r_in_range <= w_sel_in_range;
                        t_we       <= w_sel_we & w_sel_in_range;
                        t_addr     <= w_sel_in_range ? w_sel_addr : {WORD_W{1'b0}};
                        t_wd       <= w_sel_wd;
                        r_state    <= ST_ACCESS;
                    end else begin
                        t_we       <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    t_we <= 1'b0;
                    // Out-of-window reads return zero rather than whatever t_rd shows.
                    if (!r_we) begin
                        rdata <= r_in_range ? t_rd : {WORD_W{1'b0}};
                    end
                    r0_ack  <= ~owner;
                    r1_ack  <= owner;
                    r0_err  <= ~owner & ~r_in_range;
                    r1_err  <= owner & ~r_in_range;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    t_we     <= 1'b0;
                    r0_ack   <= 1'b0;
                    r0_err   <= 1'b0;
                    r1_ack   <= 1'b0;
                    r1_err   <= 1'b0;
                    r_rr_ptr <= ~owner;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    t_we    <= 1'b0;
                    r0_ack  <= 1'b0;
                    r0_err  <= 1'b0;
                    r1_ack  <= 1'b0;
                    r1_err  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
